// File: rtl/alu_pkg.sv
// Opcode and branch-condition encodings shared by the RV32I ALU and its comparator.
package alu_pkg;

  // ALU opcodes as {instr[30], funct3}; bit3 only distinguishes ADD/SUB and SRL/SRA.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Branch funct3 codes.
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the microcoded core (master) and the ALU (slave).
interface alu_if;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        cmp;
  logic [31:0] y_q;
  logic        cmp_q;

  modport master (output alu_op, a, b, input y, cmp, y_q, cmp_q);
  modport slave  (input alu_op, a, b, output y, cmp, y_q, cmp_q);
endinterface

// File: rtl/alu_cmp.sv
// Branch comparator built around the single 33-bit subtractor; the difference and
// less-than flags are exported so the ALU reuses them for SUB, SLT and SLTU.
module alu_cmp
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic        cmp,
  output logic [31:0] diff,
  output logic        lt,
  output logic        ltu
);

  logic [32:0] diff_ext;
  logic        eq;

  // Zero-extended subtract: bit 32 is the borrow, i.e. unsigned a < b.
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign diff     = diff_ext[31:0];
  assign ltu      = diff_ext[32];
  assign eq       = (diff_ext[31:0] == 32'd0);
  // With differing signs the negative operand is smaller; otherwise no overflow, so the sign bit decides.
  assign lt       = (a[31] ^ b[31]) ? a[31] : diff_ext[31];

  // NOTE: every combinational output gets a value on every path (default first) so no latch is inferred.
  always_comb begin
    cmp = 1'b0;
    unique case (funct3)
      BR_EQ:   cmp = eq;
      BR_NE:   cmp = ~eq;
      3'b010:  cmp = lt;
      3'b011:  cmp = ltu;
      BR_LT:   cmp = lt;
      BR_GE:   cmp = ~lt;
      BR_LTU:  cmp = ltu;
      BR_GEU:  cmp = ~ltu;
      default: cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: combinational result and branch flag, plus a registered copy of
// both for pipelined or debug consumers.
module alu
  import alu_pkg::*;
(
  input  logic APB_PCLK,
  input  logic APB_PRESETn,
  alu_if.slave bus
);

  logic [31:0] diff;
  logic        lt;
  logic        ltu;
  logic        cmp;
  logic [31:0] y;
  logic [4:0]  shamt;

  alu_cmp u_cmp (
    .a      (bus.a),
    .b      (bus.b),
    .funct3 (bus.alu_op[2:0]),
    .cmp    (cmp),
    .diff   (diff),
    .lt     (lt),
    .ltu    (ltu)
  );

  assign shamt = bus.b[4:0];

  always_comb begin
    y = 32'd0;
    unique case (bus.alu_op[2:0])
      ALU_ADD[2:0]:  y = bus.alu_op[3] ? diff : (bus.a + bus.b);
      ALU_SLL[2:0]:  y = bus.a << shamt;
      ALU_SLT[2:0]:  y = {31'd0, lt};
      ALU_SLTU[2:0]: y = {31'd0, ltu};
      ALU_XOR[2:0]:  y = bus.a ^ bus.b;
      ALU_SRL[2:0]:  y = bus.alu_op[3] ? 32'($signed(bus.a) >>> shamt) : (bus.a >> shamt);
      ALU_OR[2:0]:   y = bus.a | bus.b;
      ALU_AND[2:0]:  y = bus.a & bus.b;
      default:       y = 32'd0;
    endcase
  end

  assign bus.y   = y;
  assign bus.cmp = cmp;

  // NOTE: sequential state uses non-blocking assignments; the async reset clears the
  // registered copies immediately, the combinational outputs are never affected.
  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      bus.y_q   <= 32'd0;
      bus.cmp_q <= 1'b0;
    end else begin
      bus.y_q   <= y;
      bus.cmp_q <= cmp;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, randomized reference-model
// comparison and hand-written reset sequences on the registered path.
module tb_alu;

  logic APB_PCLK;
  logic APB_PRESETn;

  alu_if bus ();

  alu dut (
    .APB_PCLK    (APB_PCLK),
    .APB_PRESETn (APB_PRESETn),
    .bus         (bus)
  );

  initial APB_PCLK = 1'b0;
  always #5 APB_PCLK = ~APB_PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_y;
    logic        exp_cmp;
    bit          chk_y;
    bit          chk_cmp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics using wide signed arithmetic.
  function automatic logic [31:0] ref_y(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int unsigned sh = b % 32;
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0] wide;
    case (op[2:0])
      3'd0: wide = op[3] ? 64'(ua - ub) : 64'(ua + ub);
      3'd1: wide = 64'(ua << sh);
      3'd2: wide = (sa < sb) ? 64'd1 : 64'd0;
      3'd3: wide = (ua < ub) ? 64'd1 : 64'd0;
      3'd4: wide = 64'(ua ^ ub);
      3'd5: wide = op[3] ? 64'(sa >>> sh) : 64'(ua >> sh);
      3'd6: wide = 64'(ua | ub);
      default: wide = 64'(ua & ub);
    endcase
    return wide[31:0];
  endfunction

  function automatic logic ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op[2:0])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2, 3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd3, 3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] exp_y;
    logic        exp_cmp;

    vecs.push_back('{4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b1000, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0001, 32'h1,        32'h3F,       32'h80000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b1001, 32'h1,        32'h1F,       32'h80000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b1101, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0101, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0101, 32'h12345678, 32'h20,       32'h12345678, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0100, 32'hFFFFFFFE, 32'h2,        32'h0,        1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b1100, 32'hFFFFFFFE, 32'h2,        32'h0,        1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b0110, 32'hFFFFFFFE, 32'h2,        32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'b1110, 32'hFFFFFFFE, 32'h2,        32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'b1101, 32'hFFFFFFFE, 32'h2,        32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'b0111, 32'hFFFFFFFE, 32'h2,        32'h0,        1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b0001, 32'h5,        32'h5,        32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0});

    // Reset state, asserted with stable inputs.
    APB_PRESETn = 1'b0;
    bus.alu_op  = 4'b0000;
    bus.a       = 32'h11111111;
    bus.b       = 32'h22222222;
    #12;
    check("reset_y_q", bus.y_q, 32'h0);
    check("reset_cmp_q", {31'd0, bus.cmp_q}, 32'h0);
    @(negedge APB_PCLK);
    APB_PRESETn = 1'b1;

    // Directed vectors, applied between edges.
    foreach (vecs[i]) begin
      @(negedge APB_PCLK);
      bus.alu_op = vecs[i].op;
      bus.a      = vecs[i].a;
      bus.b      = vecs[i].b;
      #1;
      if (vecs[i].chk_y)   check($sformatf("vec%0d_y", i), bus.y, vecs[i].exp_y);
      if (vecs[i].chk_cmp) check($sformatf("vec%0d_cmp", i), {31'd0, bus.cmp}, {31'd0, vecs[i].exp_cmp});
    end

    // Randomized comparison against the model, including the registered copy.
    for (int i = 0; i < 300; i++) begin
      @(negedge APB_PCLK);
      bus.alu_op = 4'($urandom);
      bus.a      = $urandom;
      case ($urandom_range(3))
        0: bus.b = bus.a;
        1: bus.b = 32'($urandom_range(40));
        default: bus.b = $urandom;
      endcase
      exp_y   = ref_y(bus.alu_op, bus.a, bus.b);
      exp_cmp = ref_cmp(bus.alu_op, bus.a, bus.b);
      #1;
      check($sformatf("rnd%0d_op%b_y", i, bus.alu_op), bus.y, exp_y);
      check($sformatf("rnd%0d_op%b_cmp", i, bus.alu_op), {31'd0, bus.cmp}, {31'd0, exp_cmp});
      @(posedge APB_PCLK);
      #1;
      check($sformatf("rnd%0d_y_q", i), bus.y_q, exp_y);
      check($sformatf("rnd%0d_cmp_q", i), {31'd0, bus.cmp_q}, {31'd0, exp_cmp});
    end

    // Mid-stream reset between edges: registered copies clear at once, y/cmp untouched.
    @(negedge APB_PCLK);
    bus.alu_op = 4'b0000;
    bus.a      = 32'h7;
    bus.b      = 32'h7;
    @(posedge APB_PCLK);
    #1;
    check("pre_reset_y_q", bus.y_q, 32'hE);
    check("pre_reset_cmp_q", {31'd0, bus.cmp_q}, 32'h1);
    #2;
    APB_PRESETn = 1'b0;
    #1;
    check("mid_reset_y_q", bus.y_q, 32'h0);
    check("mid_reset_cmp_q", {31'd0, bus.cmp_q}, 32'h0);
    check("mid_reset_y", bus.y, 32'hE);
    check("mid_reset_cmp", {31'd0, bus.cmp}, 32'h1);

    // Held through an edge, still cleared.
    @(posedge APB_PCLK);
    #1;
    check("held_reset_y_q", bus.y_q, 32'h0);

    // Release between edges: nothing changes until the next edge, then y_q follows y.
    @(negedge APB_PCLK);
    APB_PRESETn = 1'b1;
    bus.alu_op  = 4'b1000;
    bus.a       = 32'h3;
    bus.b       = 32'h5;
    #1;
    check("release_before_edge_y_q", bus.y_q, 32'h0);
    @(posedge APB_PCLK);
    #1;
    check("release_y_q", bus.y_q, 32'hFFFFFFFE);
    check("release_cmp_q", {31'd0, bus.cmp_q}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
